// File: rtl/top.sv
// Flash regenerator: measures the f0 rise-to-rise period and emits a 50 % duty f1 locked to f0 rises.
// Optional macro F0_DEGLITCH_EN inserts a DGL_LEN-sample level filter after the synchronizer.
module top #(
  parameter int CNT_W   = 20,
  parameter int DGL_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic f0,
  output logic f1
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sync1_q, sync2_q, edge_q, src;
  logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d, hc_q, hc_d, per_new;
  logic             armed_q, armed_d, valid_q, valid_d, f1_q, f1_d;
  logic             rise, sat, latch, fire;

  if (DGL_LEN < 1) begin : g_dgl_chk
    $error("DGL_LEN must be at least 1");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= f0;
      sync2_q <= sync1_q;
      edge_q  <= src;
    end
  end

`ifdef F0_DEGLITCH_EN
  localparam int DW = $clog2(DGL_LEN + 1);

  logic          flt_q, flt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  // dcnt counts consecutive samples disagreeing with the filtered level
  always_comb begin
    flt_d  = flt_q;
    dcnt_d = '0;
    if (sync2_q != flt_q) begin
      if (dcnt_q == DW'(DGL_LEN - 1)) flt_d = sync2_q;
      else                            dcnt_d = dcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_q  <= 1'b0;
      dcnt_q <= '0;
    end else begin
      flt_q  <= flt_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign src = flt_q;
`else
  assign src = sync2_q;
`endif

  assign rise    = src & ~edge_q;
  assign sat     = (cnt_q == CNT_MAX);
  assign latch   = rise & armed_q & ~sat;
  assign per_new = latch ? cnt_q : per_q;
  // a period of 1 would give a zero-length high phase, so it never fires
  assign fire    = rise & (latch | (valid_q & ~sat)) & (per_new[CNT_W-1:1] != '0);

  always_comb begin
    cnt_d   = sat ? cnt_q : cnt_q + 1'b1;
    per_d   = per_q;
    armed_d = armed_q;
    valid_d = valid_q;
    hc_d    = hc_q;
    f1_d    = f1_q;
    if (sat) begin
      valid_d = 1'b0;
      armed_d = 1'b0;
    end
    if (rise) begin
      cnt_d   = CNT_W'(1);
      armed_d = 1'b1;
    end
    if (latch) begin
      per_d   = cnt_q;
      valid_d = 1'b1;
    end
    if (fire) begin
      f1_d = 1'b1;
      hc_d = per_new >> 1;
    end else if (f1_q) begin
      if (sat || hc_q <= CNT_W'(1)) begin
        f1_d = 1'b0;
        hc_d = '0;
      end else begin
        hc_d = hc_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      per_q   <= '0;
      hc_q    <= '0;
      armed_q <= 1'b0;
      valid_q <= 1'b0;
      f1_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      hc_q    <= hc_d;
      armed_q <= armed_d;
      valid_q <= valid_d;
      f1_q    <= f1_d;
    end
  end

  assign f1 = f1_q;

endmodule

// File: tb/tb_top.sv
// Bench for top: scaled-down periods (CNT_W=12) checked against a rise-timestamp model of f1.
module tb_top;
  localparam int CNT_W   = 12;
  localparam int DGL_LEN = 4;
  localparam int MAXC    = (1 << CNT_W) - 1;
`ifdef F0_DEGLITCH_EN
  localparam int LAT = 3 + DGL_LEN;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic f0 = 1'b0;
  logic f1;

  top #(.CNT_W(CNT_W), .DGL_LEN(DGL_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .f0(f0), .f1(f1)
  );

  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: each f0 rise at cycle r opens an event starting at r+LAT; the latest started event governs f1.
  typedef struct { int unsigned start; int unsigned len; } ev_t;
  ev_t         evq[$];
  bit          have_prev = 1'b0;
  int unsigned last_r = 0;

  function automatic void model_rise(input int unsigned r);
    ev_t e;
    e.start = r + LAT;
    e.len   = 0;
    if (have_prev && (r - last_r) < MAXC) e.len = (r - last_r) / 2;
    have_prev = 1'b1;
    last_r    = r;
    evq.push_back(e);
  endfunction

  function automatic void model_reset();
    evq.delete();
    have_prev = 1'b0;
  endfunction

  function automatic int model_f1(input int unsigned t);
    while (evq.size() > 1 && evq[1].start <= t) void'(evq.pop_front());
    if (evq.size() == 0 || evq[0].start > t) return 0;
    return (t < evq[0].start + evq[0].len) ? 1 : 0;
  endfunction

  always @(negedge clk) check("f1_model", int'(f1), model_f1(cyc));

  bit          f1_prev = 1'b0;
  int unsigned n_rise = 0, n_fall = 0, last_rise_at = 0, last_w = 0;
  always @(negedge clk) begin
    if (f1 && !f1_prev) begin
      n_rise++;
      last_rise_at = cyc;
    end
    if (!f1 && f1_prev) begin
      n_fall++;
      last_w = cyc - last_rise_at;
    end
    f1_prev = f1;
  end

  // called at a negedge; returns at the negedge of the next rise
  task automatic pulse(input int unsigned period, input int unsigned high);
    f0 = 1'b1;
    model_rise(cyc);
    repeat (high) @(negedge clk);
    f0 = 1'b0;
    repeat (period - high) @(negedge clk);
  endtask

  typedef struct {
    int unsigned period;
    int unsigned high;
    int          exp_high;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[5];
  int unsigned r3, rises0, falls0, p, h;

  initial begin
    vecs[0] = '{1000, 125, 500, LAT};
    vecs[1] = '{500,   40, 250, LAT};
    vecs[2] = '{500,  125, 250, LAT};
    vecs[3] = '{500,  200, 250, LAT};
    vecs[4] = '{415,   15, 207, LAT};

    repeat (3) @(negedge clk);
    check("reset_f1", int'(f1), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    pulse(1000, 125);
    check("first_rise_no_f1", int'(n_rise), 0);

    foreach (vecs[i]) begin
      for (int k = 0; k < 3; k++) begin
        r3 = cyc;
        pulse(vecs[i].period, vecs[i].high);
      end
      check($sformatf("vec%0d_width", i), int'(last_w), vecs[i].exp_high);
      check($sformatf("vec%0d_latency", i), int'(last_rise_at - r3), vecs[i].exp_lat);
    end

    // f0 stuck low past saturation: next rise only re-arms
    repeat (MAXC + 500) @(negedge clk);
    check("sat_f1_low", int'(f1), 0);
    rises0 = n_rise;
    pulse(300, 20);
    check("sat_rearm_only", int'(n_rise), int'(rises0));
    pulse(300, 20);
    check("sat_remeasure", int'(n_rise), int'(rises0 + 1));
    check("sat_width", int'(last_w), 150);

    // a short period arriving during a long high phase restarts it without a low glitch
    pulse(2000, 100);
    pulse(300, 100);
    check("restart_pre_high", int'(f1), 1);
    falls0 = n_fall;
    f0 = 1'b1;
    model_rise(cyc);
    repeat (40) @(negedge clk);
    f0 = 1'b0;
    repeat (LAT + 100) @(negedge clk);
    check("restart_no_glitch", int'(n_fall), int'(falls0));
    check("restart_high", int'(f1), 1);
    repeat (20) @(negedge clk);
    check("restart_new_len", int'(f1), 0);
    repeat (240 - LAT) @(negedge clk);

    // reset during a high phase
    pulse(600, 30);
    pulse(600, 30);
    f0 = 1'b1;
    model_rise(cyc);
    repeat (LAT + 20) @(negedge clk);
    check("pre_rst_high", int'(f1), 1);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check("rst_f1_async", int'(f1), 0);
    @(negedge clk);
    f0 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rises0 = n_rise;
    pulse(600, 30);
    check("rst_first_rise_arms", int'(n_rise), int'(rises0));
    pulse(600, 30);
    check("rst_second_rise_fires", int'(n_rise), int'(rises0 + 1));
    check("rst_width", int'(last_w), 300);

`ifdef F0_DEGLITCH_EN
    pulse(800, 50);
    pulse(800, 50);
    rises0 = n_rise;
    f0 = 1'b1;
    model_rise(cyc);
    repeat (50) @(negedge clk);
    f0 = 1'b0;
    repeat (500) @(negedge clk);
    f0 = 1'b1;
    repeat (2) @(negedge clk);
    f0 = 1'b0;
    repeat (248) @(negedge clk);
    pulse(800, 50);
    check("spike_ignored", int'(n_rise), int'(rises0 + 2));
    check("spike_per_kept", int'(last_w), 400);
`endif

    for (int i = 0; i < 20; i++) begin
      p = $urandom_range(1500, 40);
      h = $urandom_range(p - 8, 8);
      pulse(p, h);
    end
    f0 = 1'b0;
    repeat (800) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter CNT_W, default 20, is the width of the period counter and the period register.
REQ-002 Parameter DGL_LEN, default 4, is the number of consecutive equal samples the deglitch filter needs to accept a level change.
REQ-003 Port clk, input, 1 bit: system clock, nominal 50 MHz (20 ns); every flop updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port f0, input, 1 bit: asynchronous reference flash pulse train, 0.4-2 kHz, arbitrary duty.
REQ-006 Port f1, output, 1 bit, registered: regenerated flash at the measured f0 period, 50 % duty, phase-locked to f0 rising edges.

Function
REQ-007 f0 SHALL pass through a 2-flop synchronizer and then an edge-detect flop; a one-cycle rise pulse fires when the synchronized value is 1 and the delayed value is 0.
REQ-008 Rise-pulse latency SHALL be 3 clk cycles after the f0 transition, excluding the filter delay of REQ-020.
REQ-009 Period counter cnt (CNT_W bits): +1 every cycle, saturates at 2^CNT_W-1, loads 1 on a rise pulse.
REQ-010 On a rise pulse with armed=1 and cnt not saturated: per <= cnt (clk cycles between consecutive rise pulses) and valid <= 1.
REQ-011 Every rise pulse SHALL set armed <= 1; the first rise after reset only arms and never latches per.
REQ-012 When cnt reaches saturation: valid <= 0, armed <= 0, and the next rise pulse only re-arms.
REQ-013 High-phase counter hc (CNT_W bits): on a rise pulse with a valid period (newly latched or previous), f1 <= 1 and hc <= per_new >> 1 (floor).
REQ-014 While f1=1, hc decrements each cycle; f1 <= 0 in the cycle hc reaches 1, so the high time is exactly floor(per/2) cycles.
REQ-015 A rise pulse during the high phase restarts the high phase (f1 stays 1, hc reloads); no low glitch is allowed.
REQ-016 f1 SHALL stay 0 whenever valid=0, and after its high phase until the next rise pulse (no free-running).
REQ-017 A period change SHALL take effect at the rise pulse that measures it, using the new per.

Reset
REQ-018 rst_n=0 clears immediately: synchronizer, edge and filter flops, cnt, per, hc, armed, valid, and f1 (f1=0).
REQ-019 After rst_n deasserts mid-operation, f1 stays 0 until two rise pulses have been seen (re-measurement).

Configuration
REQ-020 With macro F0_DEGLITCH_EN defined: the synchronized f0 passes a filter that changes its output only after DGL_LEN consecutive equal samples, adding DGL_LEN cycles of latency; pulses shorter than DGL_LEN cycles are ignored.
REQ-021 Without F0_DEGLITCH_EN: no filter; the edge detector uses the synchronizer output directly and latency is per REQ-008.

Verification
REQ-022 Reset, then f0 period 2 ms (high 250 us, low 1750 us) -> no f1 after the first rise; after the second rise, per=100000 and f1 high for 50000 cycles each period.
REQ-023 Switch to 1 ms period (high 80-250 us, varying) -> per=50000 and f1 high 25000 cycles, independent of f0 duty.
REQ-024 Period 830 us (high 30 us) -> per=41500, f1 high 20750 cycles, f1 rising 3 cycles after each f0 rise (define off).
REQ-025 Stop f0 at 0 for over 21 ms -> cnt saturates, valid=0, f1=0; the next rise only re-arms.
REQ-026 Assert rst_n=0 during an f1 high phase -> f1=0 immediately; two new rises are needed before f1 pulses.
REQ-027 With F0_DEGLITCH_EN, a 2-cycle f0 spike between pulses -> no rise pulse, per unchanged, f1 unaffected.
